// File: rtl/obstacle_spawner.sv
// Obstacle spawn scheduler: waits a level-dependent, LFSR-jittered number of frames,
// picks cactus or bird, waits for that obstacle's slot to free up, then pulses its spawn line.
module obstacle_spawner #(
  parameter logic [15:0] LfsrSeed     = 16'hACE1,
  parameter int          MinGapFrames = 40,
  parameter int          MaxExtraGap  = 63,
  parameter int          BirdMinLevel = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       next_frame_i,
  input  logic       game_active_i,
  input  logic [2:0] level_i,
  input  logic       cactus_busy_i,
  input  logic       bird_busy_i,
  output logic       cactus_spawn_o,
  output logic       bird_spawn_o,
  output logic [7:0] rand_o
);

  // An all-zero seed would lock the LFSR, so it is substituted.
  localparam logic [15:0] Seed      = (LfsrSeed == 16'h0000) ? 16'h0001 : LfsrSeed;
  localparam logic [5:0]  ExtraMask = 6'(MaxExtraGap);
  localparam logic [8:0]  MinGap9   = 9'(MinGapFrames);
  localparam logic [3:0]  BirdLvl   = 4'(BirdMinLevel);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GAP       = 3'd1,
    CHOOSE    = 3'd2,
    WAIT_SLOT = 3'd3,
    SPAWN     = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic        bird_sel_q, bird_sel_d;
  logic        cactus_spawn_q, cactus_spawn_d;
  logic        bird_spawn_q, bird_spawn_d;
  logic [7:0]  rand_q, rand_d;

  logic [8:0]  level_x4;
  logic [7:0]  gap_base;
  logic [7:0]  gap_load;
  logic        choose_bird;
  logic        spawn_now;

  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  // Base gap shrinks by 4 frames per level but never below 16 frames.
  assign level_x4 = {4'b0000, level_i, 2'b00};
  always_comb begin
    gap_base = 8'd16;
    if (MinGap9 >= level_x4 + 9'd16) begin
      gap_base = 8'(MinGap9 - level_x4);
    end
  end
  assign gap_load    = gap_base + {2'b00, lfsr_q[5:0] & ExtraMask};
  assign choose_bird = ({1'b0, level_i} >= BirdLvl) && (lfsr_q[7:6] == 2'b11);

  always_comb begin
    state_d    = state_q;
    gap_cnt_d  = gap_cnt_q;
    bird_sel_d = bird_sel_q;
    case (state_q)
      IDLE: begin
        if (game_active_i) begin
          state_d   = GAP;
          gap_cnt_d = gap_load;
        end
      end
      GAP: begin
        if (next_frame_i) begin
          if (gap_cnt_q <= 8'd1) begin
            gap_cnt_d = 8'd0;
            state_d   = CHOOSE;
          end else begin
            gap_cnt_d = gap_cnt_q - 8'd1;
          end
        end
      end
      CHOOSE: begin
        bird_sel_d = choose_bird;
        if (choose_bird ? bird_busy_i : cactus_busy_i) state_d = WAIT_SLOT;
        else                                           state_d = SPAWN;
      end
      WAIT_SLOT: begin
        if (!(bird_sel_q ? bird_busy_i : cactus_busy_i)) state_d = SPAWN;
      end
      SPAWN: begin
        state_d   = GAP;
        gap_cnt_d = gap_load;
      end
      default: state_d = IDLE;
    endcase
    if (!game_active_i) begin
      state_d = IDLE;
    end
  end

  // Spawn pulses are registered on entry to SPAWN so they coincide with that state.
  assign spawn_now      = (state_d == SPAWN);
  assign cactus_spawn_d = spawn_now && !bird_sel_d;
  assign bird_spawn_d   = spawn_now && bird_sel_d;
  assign rand_d         = spawn_now ? lfsr_q[15:8] : rand_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      lfsr_q         <= Seed;
      gap_cnt_q      <= 8'd0;
      bird_sel_q     <= 1'b0;
      cactus_spawn_q <= 1'b0;
      bird_spawn_q   <= 1'b0;
      rand_q         <= 8'h00;
    end else begin
      state_q        <= state_d;
      lfsr_q         <= lfsr_d;
      gap_cnt_q      <= gap_cnt_d;
      bird_sel_q     <= bird_sel_d;
      cactus_spawn_q <= cactus_spawn_d;
      bird_spawn_q   <= bird_spawn_d;
      rand_q         <= rand_d;
    end
  end

  assign cactus_spawn_o = cactus_spawn_q;
  assign bird_spawn_o   = bird_spawn_q;
  assign rand_o         = rand_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
// Directed bench for obstacle_spawner: two instances with fixed gaps (40 and 20 frames)
// share all inputs; an LFSR reference model supplies expected rand_o values.
module tb_obstacle_spawner;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       next_frame = 1'b0;
  logic       game_active = 1'b0;
  logic [2:0] level = 3'd0;
  logic       cactus_busy = 1'b0;
  logic       bird_busy = 1'b0;
  logic       c40, b40, c20, b20;
  logic [7:0] r40, r20;

  int checks = 0;
  int errors = 0;

  logic [15:0] model_lfsr = 16'h0000;
  logic [15:0] model_prev = 16'h0000;

  always #5 clk = ~clk;

  obstacle_spawner #(.LfsrSeed(16'hACE1), .MinGapFrames(40), .MaxExtraGap(0), .BirdMinLevel(2)) dut (
    .clk_i(clk), .rst_i(rst), .next_frame_i(next_frame), .game_active_i(game_active),
    .level_i(level), .cactus_busy_i(cactus_busy), .bird_busy_i(bird_busy),
    .cactus_spawn_o(c40), .bird_spawn_o(b40), .rand_o(r40)
  );

  obstacle_spawner #(.LfsrSeed(16'hACE1), .MinGapFrames(20), .MaxExtraGap(0), .BirdMinLevel(2)) dut20 (
    .clk_i(clk), .rst_i(rst), .next_frame_i(next_frame), .game_active_i(game_active),
    .level_i(level), .cactus_busy_i(cactus_busy), .bird_busy_i(bird_busy),
    .cactus_spawn_o(c20), .bird_spawn_o(b20), .rand_o(r20)
  );

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  always @(posedge clk) begin
    model_prev <= model_lfsr;
    if (rst) model_lfsr <= 16'hACE1;
    else     model_lfsr <= lfsr_step(model_lfsr);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; game_active = 1'b0; next_frame = 1'b0;
    cactus_busy = 1'b0; bird_busy = 1'b0; level = 3'd0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic send_frames(input int n);
    for (int i = 0; i < n; i++) begin
      next_frame = 1'b1; step(); next_frame = 1'b0;
      step(); step(); step();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dut.lfsr_q !== 16'hACE1) begin errors++; $display("FAIL reset_lfsr: got %h expected ace1", dut.lfsr_q); end
    checks++;
    if ({c40, b40, c20, b20} !== 4'b0000) begin errors++; $display("FAIL reset_spawn: got %b expected 0000", {c40, b40, c20, b20}); end
    checks++;
    if (r40 !== 8'h00 || r20 !== 8'h00) begin errors++; $display("FAIL reset_rand: got %h/%h expected 00", r40, r20); end
    checks++;
    if (int'(dut.state_q) !== 0 || dut.gap_cnt_q !== 8'd0) begin
      errors++; $display("FAIL reset_state: got state %0d cnt %0d expected 0 0", int'(dut.state_q), dut.gap_cnt_q);
    end
    $display("test_reset: lfsr=%h rand=%h", dut.lfsr_q, r40);
  endtask

  task automatic test_lfsr_period();
    int mism = 0;
    int zeros = 0;
    int first_ret = -1;
    do_reset();
    for (int i = 1; i <= 65535; i++) begin
      step();
      if (dut.lfsr_q !== model_lfsr) mism++;
      if (dut.lfsr_q == 16'h0000) zeros++;
      if (first_ret < 0 && dut.lfsr_q == 16'hACE1) first_ret = i;
    end
    checks++;
    if (mism != 0) begin errors++; $display("FAIL lfsr_sequence: got %0d mismatching cycles expected 0", mism); end
    checks++;
    if (zeros != 0) begin errors++; $display("FAIL lfsr_zero: got %0d zero states expected 0", zeros); end
    checks++;
    if (first_ret != 65535) begin errors++; $display("FAIL lfsr_period: got %0d expected 65535", first_ret); end
    $display("test_lfsr_period: period=%0d", first_ret);
  endtask

  // Four-cycle frames; a pulse must appear exactly two cycles after each gap-expiring frame.
  task automatic run_frames(input int n, input logic [2:0] lvl, input int gap_a, input int gap_b, input string name);
    int pulses_a = 0;
    int pulses_b = 0;
    logic exp_a, exp_b;
    do_reset();
    level = lvl; game_active = 1'b1;
    step();
    for (int f = 1; f <= n; f++) begin
      next_frame = 1'b1; step(); next_frame = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        if (k > 1) step();
        exp_a = (k == 2) && (f % gap_a == 0);
        exp_b = (k == 2) && (f % gap_b == 0);
        checks++;
        if ((c40 | b40) !== exp_a) begin
          errors++; $display("FAIL %s_a: frame %0d cyc %0d got %b expected %b", name, f, k, c40 | b40, exp_a);
        end
        checks++;
        if ((c20 | b20) !== exp_b) begin
          errors++; $display("FAIL %s_b: frame %0d cyc %0d got %b expected %b", name, f, k, c20 | b20, exp_b);
        end
        checks++;
        if ((c40 & b40) !== 1'b0 || (c20 & b20) !== 1'b0) begin
          errors++; $display("FAIL %s_both: frame %0d got %b%b%b%b expected no double pulse", name, f, c40, b40, c20, b20);
        end
        if (exp_a) begin
          pulses_a++;
          checks++;
          if (r40 !== model_prev[15:8]) begin errors++; $display("FAIL %s_rand: got %h expected %h", name, r40, model_prev[15:8]); end
        end
        if (exp_b) pulses_b++;
      end
    end
    game_active = 1'b0;
    step();
    checks++;
    if (int'(dut.state_q) !== 0 || int'(dut20.state_q) !== 0) begin
      errors++; $display("FAIL %s_idle: got %0d/%0d expected 0", name, int'(dut.state_q), int'(dut20.state_q));
    end
    $display("%s: %0d frames, pulses gap%0d=%0d gap%0d=%0d", name, n, gap_a, pulses_a, gap_b, pulses_b);
  endtask

  task automatic test_fixed_gap();
    run_frames(60, 3'd0, 40, 20, "fixed_gap");
  endtask

  task automatic test_level_clamp();
    run_frames(40, 3'd5, 20, 16, "level5");
    run_frames(32, 3'd7, 16, 16, "level7");
  endtask

  task automatic test_busy_stall();
    int stray = 0;
    do_reset();
    level = 3'd0; cactus_busy = 1'b1; game_active = 1'b1;
    step();
    send_frames(39);
    next_frame = 1'b1; step(); next_frame = 1'b0;
    checks++;
    if (int'(dut.state_q) !== 2) begin errors++; $display("FAIL stall_choose: got state %0d expected 2", int'(dut.state_q)); end
    for (int i = 1; i <= 100; i++) begin
      next_frame = (i % 4 == 0);
      step();
      if (c40 | b40) stray++;
    end
    next_frame = 1'b0;
    checks++;
    if (stray != 0) begin errors++; $display("FAIL stall_pulse: got %0d pulses expected 0", stray); end
    checks++;
    if (int'(dut.state_q) !== 3) begin errors++; $display("FAIL stall_wait: got state %0d expected 3", int'(dut.state_q)); end
    cactus_busy = 1'b0;
    step();
    checks++;
    if ({c40, b40} !== 2'b10) begin errors++; $display("FAIL stall_release: got %b%b expected 10", c40, b40); end
    step();
    checks++;
    if ({c40, b40} !== 2'b00 || dut.gap_cnt_q !== 8'd40) begin
      errors++; $display("FAIL stall_reload: got pulse %b%b cnt %0d expected 00 40", c40, b40, dut.gap_cnt_q);
    end
    game_active = 1'b0;
    step();
    $display("test_busy_stall: released after 100-cycle stall");
  endtask

  task automatic test_bird_gating();
    int birds = 0;
    int cacti = 0;
    int both = 0;
    int rbad = 0;
    do_reset();
    level = 3'd0; game_active = 1'b1; next_frame = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) level = 3'd1;
      step();
      if (b40 | b20) birds++;
      if (c40) cacti++;
    end
    checks++;
    if (birds != 0) begin errors++; $display("FAIL bird_low_level: got %0d bird pulses expected 0", birds); end
    checks++;
    if (cacti < 200 || cacti > 300) begin errors++; $display("FAIL cactus_rate: got %0d expected 200..300", cacti); end
    $display("test_bird_gating low: birds=%0d cacti=%0d", birds, cacti);
    birds = 0; cacti = 0;
    level = 3'd7;
    for (int i = 0; i < 6000; i++) begin
      next_frame = 1'($urandom_range(0, 1));
      step();
      if (c40 & b40) both++;
      if (b40) birds++;
      if (c40) cacti++;
      if ((c40 | b40) && r40 !== model_prev[15:8]) rbad++;
    end
    game_active = 1'b0; next_frame = 1'b0;
    step();
    checks++;
    if (both != 0) begin errors++; $display("FAIL bird_coincident: got %0d expected 0", both); end
    checks++;
    if (rbad != 0) begin errors++; $display("FAIL bird_rand: got %0d bad values expected 0", rbad); end
    checks++;
    if (birds + cacti < 100 || birds * 100 < 10 * (birds + cacti) || birds * 100 > 40 * (birds + cacti)) begin
      errors++; $display("FAIL bird_ratio: got %0d birds of %0d expected 10..40 percent", birds, birds + cacti);
    end
    $display("test_bird_gating level7: birds=%0d cacti=%0d", birds, cacti);
  endtask

  task automatic test_abort();
    int stray = 0;
    do_reset();
    level = 3'd0; game_active = 1'b1;
    step();
    send_frames(5);
    game_active = 1'b0;
    step();
    checks++;
    if (int'(dut.state_q) !== 0 || {c40, b40} !== 2'b00) begin
      errors++; $display("FAIL abort_gap: got state %0d pulse %b%b expected 0 00", int'(dut.state_q), c40, b40);
    end
    game_active = 1'b1; cactus_busy = 1'b1;
    step();
    send_frames(39);
    next_frame = 1'b1; step(); next_frame = 1'b0;
    step();
    checks++;
    if (int'(dut.state_q) !== 3) begin errors++; $display("FAIL abort_wait: got state %0d expected 3", int'(dut.state_q)); end
    rst = 1'b1;
    step();
    rst = 1'b0; cactus_busy = 1'b0;
    checks++;
    if (int'(dut.state_q) !== 0 || {c40, b40} !== 2'b00 || dut.lfsr_q !== 16'hACE1) begin
      errors++; $display("FAIL abort_reset: got state %0d pulse %b%b lfsr %h expected 0 00 ace1", int'(dut.state_q), c40, b40, dut.lfsr_q);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      if (c40 | b40) stray++;
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL abort_after: got %0d pulses expected 0", stray); end
    game_active = 1'b0;
    step();
    $display("test_abort: done");
  endtask

  initial begin
    test_reset();
    test_lfsr_period();
    test_fixed_gap();
    test_level_clamp();
    test_busy_stall();
    test_bird_gating();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
